// File: rtl/rs_bank_if.sv
// Reservation-station bank bus: issue, CDB, dispatch and completion.
// The station side uses the slave modport; the producer/FU side uses master.
interface rs_bank_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 3
);
  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [XLEN-1:0]  issue_vj;
  logic [XLEN-1:0]  issue_vk;
  logic [TAG_W-1:0] issue_qj;
  logic [TAG_W-1:0] issue_qk;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_vj;
  logic [XLEN-1:0]  disp_vk;
  logic [TAG_W-1:0] disp_tag;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk,
    output issue_qj, issue_qk, issue_tag,
    output cdb_valid, cdb_tag, cdb_data, disp_ready,
    input  issue_ready, disp_valid, disp_op, disp_vj,
    input  disp_vk, disp_tag, done_valid, done_tag
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk,
    input  issue_qj, issue_qk, issue_tag,
    input  cdb_valid, cdb_tag, cdb_data, disp_ready,
    output issue_ready, disp_valid, disp_op, disp_vj,
    output disp_vk, disp_tag, done_valid, done_tag
  );
endinterface

// File: rtl/rs_bank.sv
// Tomasulo reservation-station bank: issue with CDB bypass, operand
// capture, lowest-index dispatch, fixed-latency execute and completion.
module rs_bank #(
  parameter int ENTRIES = 4,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 3,
  parameter int EXE_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  rs_bank_if.slave    io,
  output logic [4:0]  busy_cnt
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    S_FREE, S_WAIT, S_READY, S_EXEC
  } st_e;

  typedef struct packed {
    st_e              st;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] tag;
    logic [3:0]       tmr;
  } ent_t;

  ent_t ent_q [ENTRIES];
  ent_t ent_d [ENTRIES];
  ent_t new_ent;

  logic          free_hit, rdy_hit, done_hit;
  logic [IW-1:0] free_idx, rdy_idx, done_idx;
  logic [4:0]    cnt;
  logic          cdb_hit, iss_fire, disp_fire;

  // Priority scans: lowest index wins, so iterate high to low
  always_comb begin
    free_hit = 1'b0;
    rdy_hit  = 1'b0;
    done_hit = 1'b0;
    free_idx = '0;
    rdy_idx  = '0;
    done_idx = '0;
    cnt      = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_q[i].st == S_FREE) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_q[i].st == S_READY) begin
        rdy_hit = 1'b1;
        rdy_idx = IW'(i);
      end
      if (ent_q[i].st == S_EXEC && ent_q[i].tmr == '0) begin
        done_hit = 1'b1;
        done_idx = IW'(i);
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_q[i].st != S_FREE) cnt = cnt + 5'd1;
    end
  end

  assign busy_cnt       = cnt;
  assign io.issue_ready = free_hit;
  assign io.disp_valid  = rdy_hit;
  assign io.disp_op     = rdy_hit ? ent_q[rdy_idx].op  : '0;
  assign io.disp_vj     = rdy_hit ? ent_q[rdy_idx].vj  : '0;
  assign io.disp_vk     = rdy_hit ? ent_q[rdy_idx].vk  : '0;
  assign io.disp_tag    = rdy_hit ? ent_q[rdy_idx].tag : '0;
  assign io.done_valid  = done_hit && !flush;
  assign io.done_tag    = io.done_valid ? ent_q[done_idx].tag : '0;

  assign cdb_hit   = io.cdb_valid && (io.cdb_tag != '0);
  assign iss_fire  = io.issue_valid && free_hit && !flush;
  assign disp_fire = rdy_hit && io.disp_ready;

  // Incoming instruction with same-cycle CDB bypass on both operands
  always_comb begin
    new_ent     = '0;
    new_ent.op  = io.issue_op;
    new_ent.tag = io.issue_tag;
    new_ent.vj  = io.issue_vj;
    new_ent.vk  = io.issue_vk;
    new_ent.qj  = io.issue_qj;
    new_ent.qk  = io.issue_qk;
    if (cdb_hit && io.issue_qj == io.cdb_tag) begin
      new_ent.vj = io.cdb_data;
      new_ent.qj = '0;
    end
    if (cdb_hit && io.issue_qk == io.cdb_tag) begin
      new_ent.vk = io.cdb_data;
      new_ent.qk = '0;
    end
    new_ent.st = (new_ent.qj == '0 && new_ent.qk == '0) ? S_READY : S_WAIT;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (flush) begin
        ent_d[i].st = S_FREE;
      end else begin
        unique case (ent_q[i].st)
          S_FREE: begin
            if (iss_fire && free_idx == IW'(i)) ent_d[i] = new_ent;
          end
          S_WAIT: begin
            if (cdb_hit && ent_q[i].qj == io.cdb_tag) begin
              ent_d[i].vj = io.cdb_data;
              ent_d[i].qj = '0;
            end
            if (cdb_hit && ent_q[i].qk == io.cdb_tag) begin
              ent_d[i].vk = io.cdb_data;
              ent_d[i].qk = '0;
            end
            if (ent_d[i].qj == '0 && ent_d[i].qk == '0)
              ent_d[i].st = S_READY;
          end
          S_READY: begin
            if (disp_fire && rdy_idx == IW'(i)) begin
              ent_d[i].st  = S_EXEC;
              ent_d[i].tmr = 4'(EXE_LAT - 1);
            end
          end
          S_EXEC: begin
            // A finished entry parks at zero until it wins the done port
            if (ent_q[i].tmr != '0)
              ent_d[i].tmr = ent_q[i].tmr - 4'd1;
            else if (done_hit && done_idx == IW'(i))
              ent_d[i].st = S_FREE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule
